// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the ALU writeback always wins, long-latency
// results drain from a small FIFO, and a pending scoreboard tracks outstanding results.
module regfile_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            regwrite,
  output logic [4:0]      writereg,
  output logic [XLEN-1:0] writedata,
  output logic [31:0]     pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // One-hot select of registers 1..31; register 0 never appears.
  function automatic logic [31:1] reg_onehot(input logic en, input logic [4:0] rd);
    logic [31:1] r;
    for (int i = 1; i < 32; i++) begin
      r[i] = en && (rd == 5'(i));
    end
    return r;
  endfunction

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;

  logic            push_p0, pop_p0, alu_take_p0;
  logic [4:0]      head_rd_p0;
  logic [XLEN-1:0] head_data_p0;
  logic [31:1]     pend_set_p0, pend_clr_p0;

  logic            vld_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] data_p1;
  logic [31:1]     pend_p1;

  // Stage p0: arbitration and FIFO head decode.
  always_comb begin
    lsu_ready    = (cnt < FULL_CNT);
    push_p0      = lsu_valid && lsu_ready;
    alu_take_p0  = alu_valid && (alu_rd != 5'd0);
    pop_p0       = !alu_take_p0 && (cnt != '0);
    head_rd_p0   = fifo_rd[rd_ptr];
    head_data_p0 = fifo_data[rd_ptr];
    pend_set_p0  = reg_onehot(issue_valid, issue_rd);
    pend_clr_p0  = reg_onehot(pop_p0, head_rd_p0);
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      fifo_rd[wr_ptr]   <= lsu_rd;
      fifo_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage p1: registered write port and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      pend_p1 <= '0;
    end else begin
      vld_p1  <= alu_take_p0 || (pop_p0 && head_rd_p0 != 5'd0);
      if (alu_take_p0) begin
        rd_p1   <= alu_rd;
        data_p1 <= alu_data;
      end else if (pop_p0 && head_rd_p0 != 5'd0) begin
        rd_p1   <= head_rd_p0;
        data_p1 <= head_data_p0;
      end
      // A same-cycle issue re-arms the bit even while the older result retires.
      pend_p1 <= (pend_p1 & ~pend_clr_p0) | pend_set_p0;
    end
  end

  assign regwrite  = vld_p1;
  assign writereg  = rd_p1;
  assign writedata = data_p1;
  assign pending   = {pend_p1, 1'b0};

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic alu_valid, lsu_valid, issue_valid, lsu_ready, regwrite;
  logic [4:0] alu_rd, lsu_rd, issue_rd, writereg;
  logic [XLEN-1:0] alu_data, lsu_data, writedata;
  logic [31:0] pending;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
    .pending(pending)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            q[$];
  logic [31:0]     m_pend;
  logic            m_we;
  logic [4:0]      m_wr;
  logic [XLEN-1:0] m_wd;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = '0;
    m_we   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".regwrite"},  {31'd0, regwrite}, {31'd0, m_we});
    chk({tag, ".writereg"},  {27'd0, writereg}, {27'd0, m_wr});
    chk({tag, ".writedata"}, writedata, m_wd);
    chk({tag, ".pending"},   pending, m_pend);
  endtask

  // One clock: drive inputs, check ready, advance the model, check registered outputs.
  task automatic step(input string tag,
                      input logic a_v, input logic [4:0] a_rd, input logic [XLEN-1:0] a_d,
                      input logic l_v, input logic [4:0] l_rd, input logic [XLEN-1:0] l_d,
                      input logic i_v, input logic [4:0] i_rd);
    ent_t e;
    logic room;
    @(negedge clk);
    alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
    lsu_valid = l_v; lsu_rd = l_rd; lsu_data = l_d;
    issue_valid = i_v; issue_rd = i_rd;
    #1;
    room = (q.size() < DEPTH);
    chk({tag, ".lsu_ready"}, {31'd0, lsu_ready}, {31'd0, room});
    if (a_v && a_rd != 0) begin
      m_we = 1'b1; m_wr = a_rd; m_wd = a_d;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = (e.rd != 0);
      if (e.rd != 0) begin
        m_wr = e.rd; m_wd = e.data; m_pend[e.rd] = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end
    if (i_v && i_rd != 0) m_pend[i_rd] = 1'b1;
    if (l_v && room) q.push_back('{rd: l_rd, data: l_d});
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset.lsu_ready", {31'd0, lsu_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU single write
    step("t1a", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    chk("t1.data_const", writedata, 32'hDEADBEEF);
    idle("t1b");
    chk("t1.drop", {31'd0, regwrite}, 32'd0);

    // Issue then LSU result retires and clears pending
    step("t2a", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7);
    chk("t2.pend7", pending, 32'h0000_0080);
    step("t2b", 1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
    idle("t2c");
    chk("t2.pend_clr", pending, 32'h0);
    chk("t2.wr7", {27'd0, writereg}, 32'd7);

    // ALU starves FIFO; FIFO fills and drains in order
    step("t3a", 1'b1, 5'd10, 32'hA0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    step("t3b", 1'b1, 5'd11, 32'hA1, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
    step("t3c", 1'b1, 5'd12, 32'hA2, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
    step("t3d", 1'b1, 5'd13, 32'hA3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
    idle("t3e");
    chk("t3.first_pop", {27'd0, writereg}, 32'd3);
    idle("t3f");
    idle("t3g");

    // rd=0 ALU is discarded and does not block a pop; rd=0 FIFO entry pops silently
    step("t4a", 1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    step("t4b", 1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0);
    chk("t4.wr9", {27'd0, writereg}, 32'd9);
    idle("t4c");
    chk("t4.silent", {31'd0, regwrite}, 32'd0);

    // Set wins over clear on the same register
    step("t5a", 1'b0, 5'd0, '0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd6);
    step("t5b", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd6);
    chk("t5.pend6", pending, 32'h0000_0040);
    idle("t5c");

    // Reset mid-stream
    step("t6a", 1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h70, 1'b1, 5'd7);
    step("t6b", 1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'h80, 1'b1, 5'd8);
    chk("t6.pend", pending, 32'h0000_01C0);
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t6.rst");
    chk("t6.rst_ready", {31'd0, lsu_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle("t6c");
    idle("t6d");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rnd",
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom(),
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end
    for (int n = 0; n < 4; n++) idle("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Writer side of the 32x32 register file's single write port. Merges two producers into one registered write stream: the single-cycle ALU writeback path, which cannot stall, and the long-latency LSU/mul-div result path, which uses valid/ready and is buffered in a small FIFO. Also keeps a pending-write scoreboard so decode can stall on registers awaiting a long-latency result.

Parameters:
DEPTH, 2, LSU result FIFO entries; must be a power of 2 and at least 2.
XLEN, 32, data width.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
alu_valid  input  1  ALU result present this cycle; always accepted.
alu_rd  input  5  ALU destination register.
alu_data  input  XLEN  ALU result.
lsu_valid  input  1  long-latency result offered.
lsu_ready  output  1  FIFO can accept; equals not full.
lsu_rd  input  5  long-latency destination register.
lsu_data  input  XLEN  long-latency result.
issue_valid  input  1  a long-latency op issued this cycle.
issue_rd  input  5  destination of the issued op.
regwrite  output  1  register-file write enable, registered.
writereg  output  5  register-file write address, registered.
writedata  output  XLEN  register-file write data, registered.
pending  output  32  scoreboard bit per register; bit 0 always 0.

Behaviour:
- Reset, async on rst_n low: regwrite=0, writereg=0, writedata=0, FIFO empty with pointers=0, pending=0. lsu_ready=1 while FIFO is empty, including during reset.
- LSU push: occurs when lsu_valid && lsu_ready. There is no pass-through; an entry spends at least one cycle in the FIFO.
- Output select per cycle, evaluated at the clock edge:
  - alu_valid && alu_rd!=0: ALU wins. regwrite=1, writereg=alu_rd, writedata=alu_data.
  - Otherwise, if FIFO not empty: pop head. If head rd!=0, regwrite=1 with head rd/data; if head rd==0, the pop is silent and regwrite=0.
  - Otherwise: regwrite=0. writereg and writedata hold their last values.
- alu_valid with alu_rd==0 is discarded. It does not block a FIFO pop in that cycle.
- Latency: ALU accepted in cycle N gives regwrite in N+1. LSU accepted in cycle N gives regwrite no earlier than N+2.
- FIFO order is strictly preserved. The ALU can starve the FIFO indefinitely; the upstream pipeline guarantees gaps.
- Push and pop in the same cycle is allowed when the FIFO is not full. Occupancy is unchanged.
- lsu_ready is combinational from occupancy only (count<DEPTH). It does not depend on alu_valid or any other same-cycle input.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A separate occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Scoreboard:
  - issue_valid && issue_rd!=0 sets pending[issue_rd] at the next edge.
  - A FIFO pop with rd!=0 clears pending[rd] at the same edge regwrite is registered.
  - Set and clear of the same bit in one cycle: set wins.
  - ALU writes never touch pending.
  - pending[0] is constant 0.
- Reset asserted mid-operation: all buffered FIFO entries are discarded and pending is cleared. No regwrite pulse occurs during reset or in the first cycle after release unless an input is accepted.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle regwrite=1, writereg=5, writedata=0xDEADBEEF; regwrite=0 the following cycle.
2. issue_valid rd=7, then lsu push rd=7 data=0x1234 with the ALU idle -> pending[7]=1 one cycle after issue; regwrite rd=7 two cycles after push; pending[7]=0 on that same edge.
3. alu_valid=1 for 4 cycles while lsu pushes rd=3 then rd=4 (DEPTH=2) -> lsu_ready=0 after the 2nd push; the 4 ALU writes come out first, then rd=3, then rd=4 in order; lsu_ready returns to 1 after the first pop.
4. alu_rd=0 with alu_valid=1 while the FIFO holds rd=9 -> no ALU write; rd=9 is written next cycle. A FIFO entry with rd=0 pops with regwrite=0.
5. Same cycle: issue_valid rd=6 and a FIFO pop of rd=6 -> pending[6] remains 1.
6. Fill the FIFO, set pending=0x0000_0180, then assert rst_n=0 mid-stream -> outputs 0, pending=0, lsu_ready=1 immediately; after release, no stale writes appear.
